// File: rtl/bcd_counter_n.sv
// Cascaded N-decade BCD up/down counter with prescaler, parallel load,
// terminal-count, wrap pulse and sticky overflow flag.
module bcd_counter_n #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clock_50,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  clr_ovf,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  ovf
);

    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    logic [4*DIGITS-1:0] r_q;
    logic [15:0]         r_pcnt;
    logic                r_wrap;
    logic                r_ovf;

    logic [4*DIGITS-1:0] w_q_step;
    logic [4*DIGITS-1:0] w_load_val;
    logic [3:0]          w_d;
    logic [3:0]          w_din_d;
    logic                w_carry;
    logic                w_all9;
    logic                w_all0;
    logic                w_step;
    logic                w_wrap_step;

    // Ripple carry/borrow through the decades; digits past the last carry hold.
    always_comb begin
        w_q_step   = '0;
        w_load_val = '0;
        w_d        = '0;
        w_din_d    = '0;
        w_carry    = 1'b1;
        w_all9     = 1'b1;
        w_all0     = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_d     = r_q[4*i +: 4];
            w_din_d = din[4*i +: 4];
            if (w_d != 4'd9) w_all9 = 1'b0;
            if (w_d != 4'd0) w_all0 = 1'b0;
            if (!w_carry) begin
                w_q_step[4*i +: 4] = w_d;
            end else if (up) begin
                if (w_d >= 4'd9) begin
                    w_q_step[4*i +: 4] = 4'd0;
                end else begin
                    w_q_step[4*i +: 4] = w_d + 4'd1;
                    w_carry = 1'b0;
                end
            end else begin
                if (w_d == 4'd0) begin
                    w_q_step[4*i +: 4] = 4'd9;
                end else begin
                    w_q_step[4*i +: 4] = w_d - 4'd1;
                    w_carry = 1'b0;
                end
            end
            w_load_val[4*i +: 4] = (w_din_d > 4'd9) ? 4'd0 : w_din_d;
        end
    end

    assign tc          = up ? w_all9 : w_all0;
    assign w_step      = en && !load && (r_pcnt == PCNT_LAST);
    assign w_wrap_step = w_step && tc;

    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_q    <= '0;
            r_pcnt <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_val;
            r_pcnt <= '0;
            r_wrap <= 1'b0;
        end else if (en) begin
            if (r_pcnt == PCNT_LAST) begin
                r_pcnt <= '0;
                r_q    <= w_q_step;
                r_wrap <= w_wrap_step;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Wrap sets the flag even when a clear is requested in the same cycle.
    always_ff @(posedge clock_50) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_step) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed self-checking bench for bcd_counter_n: two 2-digit instances,
// prescale 1 and prescale 3, sharing one stimulus stream.
module tb_bcd_counter_n;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] din;
    logic       clr_ovf;

    logic [7:0] q1, q3;
    logic       tc1, tc3, wrap1, wrap3, ovf1, ovf3;

    int checks   = 0;
    int failures = 0;

    bcd_counter_n #(.DIGITS(2), .PRESCALE(1)) u_p1 (
        .clock_50(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din), .clr_ovf(clr_ovf), .Q(q1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
    );

    bcd_counter_n #(.DIGITS(2), .PRESCALE(3)) u_p3 (
        .clock_50(clk), .reset(reset), .en(en), .up(up), .load(load),
        .din(din), .clr_ovf(clr_ovf), .Q(q3), .tc(tc3), .wrap(wrap3), .ovf(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        int n;
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 8'h00; clr_ovf = 1'b0;
        tick();
        tick();

        // reset state and tc's dependence on direction
        chk("rst_q", q1, 8'h00);
        chk("rst_wrap", wrap1, 1'b0);
        chk("rst_ovf", ovf1, 1'b0);
        chk("rst_tc_up", tc1, 1'b0);
        up = 1'b0;
        #1;
        chk("rst_tc_dn", tc1, 1'b1);
        up = 1'b1;

        // full up-count 00..99 -> 00, prescale 1
        reset = 1'b1; en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            n = k % 100;
            chk("up_q", q1, bcd2(n));
            chk("up_tc", tc1, (n == 99));
            chk("up_wrap", wrap1, (k == 100));
            chk("up_ovf", ovf1, (k == 100));
        end
        tick();
        chk("up_after_q", q1, 8'h01);
        chk("up_after_wrap", wrap1, 1'b0);
        chk("up_after_ovf", ovf1, 1'b1);

        // load 10 then count down through 00 to 99
        up = 1'b0; load = 1'b1; din = 8'h10; en = 1'b0;
        tick();
        chk("ld10_q", q1, 8'h10);
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            n = (k <= 10) ? (10 - k) : 99;
            chk("dn_q", q1, bcd2(n));
            chk("dn_tc", tc1, (n == 0));
            chk("dn_wrap", wrap1, (k == 11));
        end

        // load sanitises illegal digits and overrides en
        up = 1'b1; load = 1'b1; din = 8'hA7; en = 1'b1;
        tick();
        chk("ldA7_q", q1, 8'h07);
        chk("ldA7_wrap", wrap1, 1'b0);
        din = 8'h9B;
        tick();
        chk("ld9B_q", q1, 8'h90);

        // set-wins on ovf, then clear alone
        din = 8'h99; clr_ovf = 1'b1; en = 1'b0;
        tick();
        chk("ld99_q", q1, 8'h99);
        chk("ld99_ovf_clr", ovf1, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1; clr_ovf = 1'b1;
        tick();
        chk("setwin_q", q1, 8'h00);
        chk("setwin_ovf", ovf1, 1'b1);
        chk("setwin_wrap", wrap1, 1'b1);
        en = 1'b0;
        tick();
        chk("clr_ovf", ovf1, 1'b0);
        chk("clr_wrap", wrap1, 1'b0);
        chk("hold_q", q1, 8'h00);
        clr_ovf = 1'b0;
        tick();
        chk("hold_q2", q1, 8'h00);

        // reset mid-count with load asserted
        load = 1'b1; din = 8'h99;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        chk("pre_rst_ovf", ovf1, 1'b1);
        tick();
        chk("pre_rst_q", q1, 8'h01);
        reset = 1'b0; load = 1'b1; din = 8'h55; clr_ovf = 1'b0;
        tick();
        chk("rstld_q", q1, 8'h00);
        chk("rstld_wrap", wrap1, 1'b0);
        chk("rstld_ovf", ovf1, 1'b0);
        tick();
        chk("rstld_hold", q1, 8'h00);
        reset = 1'b1; load = 1'b0;
        tick();
        chk("rel_q", q1, 8'h01);
        // a reset pulse between edges must not act
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        chk("async_q", q1, 8'h02);

        // prescale 3 timing, with a 2-cycle enable gap mid-phase
        reset = 1'b0; en = 1'b0;
        tick();
        chk("p3_rst_q", q3, 8'h00);
        reset = 1'b1; en = 1'b1; up = 1'b1;
        tick(); chk("p3_e1", q3, 8'h00);
        tick(); chk("p3_e2", q3, 8'h00);
        tick(); chk("p3_e3", q3, 8'h01);
        tick(); chk("p3_e4", q3, 8'h01);
        tick(); chk("p3_e5", q3, 8'h01);
        tick(); chk("p3_e6", q3, 8'h02);
        tick(); chk("p3_e7", q3, 8'h02);
        en = 1'b0;
        tick(); chk("p3_e8", q3, 8'h02);
        tick(); chk("p3_e9", q3, 8'h02);
        en = 1'b1;
        tick(); chk("p3_e10", q3, 8'h02);
        tick(); chk("p3_e11", q3, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
